// File: rtl/logic_unit_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : logic_unit_seq_if
//  Brief    : Handshake/data bundle for logic_unit_seq (operand side plus
//             result side, valid/ready on both).
//  Revision : 1.0  initial release
// ============================================================================
interface logic_unit_seq_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  // Upstream (operand) side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             acc_en;
  logic             acc_clr;
  // Downstream (result) side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             parity;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] txn_cnt;

  // Source/sink of transactions (testbench or surrounding datapath)
  modport master (
    output in_valid, a, b, op, acc_en, acc_clr, out_ready,
    input  in_ready, out_valid, y, zero, parity, acc, txn_cnt
  );

  // The logic unit itself
  modport slave (
    input  in_valid, a, b, op, acc_en, acc_clr, out_ready,
    output in_ready, out_valid, y, zero, parity, acc, txn_cnt
  );
endinterface
`default_nettype wire

// File: rtl/logic_unit_seq.sv
`default_nettype none
// ============================================================================
//  Module   : logic_unit_seq
//  Brief    : Registered bitwise logic unit with one-stage valid/ready output
//             register, optional accumulate chaining, zero/parity flags and a
//             wrapping accepted-transaction counter.
//  Revision : 1.0  initial release
// ============================================================================
module logic_unit_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input wire              clk,
  input wire              rst,
  logic_unit_seq_if.slave bus
);

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] y_q,         y_d;
  logic             zero_q,      zero_d;
  logic             parity_q,    parity_d;
  logic [WIDTH-1:0] acc_q,       acc_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] acc_eff;
  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] result;

  // Datapath: pick operand B, evaluate the selected bitwise function
  always_comb begin
    acc_eff = bus.acc_clr ? '0 : acc_q;
    bb      = bus.acc_en ? acc_eff : bus.b;
    result  = '0;
    case (bus.op)
      OP_NOT:  result = ~bus.a;
      OP_AND:  result = bus.a & bb;
      OP_NAND: result = ~(bus.a & bb);
      OP_OR:   result = bus.a | bb;
      OP_NOR:  result = ~(bus.a | bb);
      OP_XOR:  result = bus.a ^ bb;
      OP_XNOR: result = ~(bus.a ^ bb);
      OP_PASS: result = bus.a;
      default: result = '0;
    endcase
  end

  // Next-state: a new accept always wins; otherwise drain and/or clear acc.
  // y and flags are only rewritten on accept, so draining leaves them intact.
  always_comb begin
    in_ready    = !out_valid_q || bus.out_ready;
    accept      = bus.in_valid && in_ready;
    out_valid_d = out_valid_q;
    y_d         = y_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      y_d         = result;
      zero_d      = (result == '0);
      parity_d    = ^result;
      acc_d       = result;
      cnt_d       = cnt_q + 1'b1;
    end else begin
      if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end
      if (bus.acc_clr) begin
        acc_d = '0;
      end
    end
  end

  // State registers; async reset leaves an empty, zeroed output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b1;
      parity_q    <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;
  assign bus.parity    = parity_q;
  assign bus.acc       = acc_q;
  assign bus.txn_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logic_unit_seq
//  Brief    : Self-checking bench for logic_unit_seq: directed scenarios plus
//             randomized traffic against a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_logic_unit_seq;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int CNT_MOD = 1 << CNT_W;

  logic clk;
  logic rst;

  logic_unit_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  logic_unit_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;

  // Reference model state: what the output register should hold
  logic       m_valid;
  logic [7:0] m_y;
  logic [7:0] m_acc;
  int         m_cnt;

  logic [7:0] sweep_exp [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [7:0] ref_fn(input int f, input logic [7:0] x, input logic [7:0] z);
    logic [7:0] ones;
    ones = 8'hFF;
    case (f)
      0: return ones - x;
      1: return x & z;
      2: return ones - (x & z);
      3: return x | z;
      4: return ones - (x | z);
      5: return x ^ z;
      6: return ones - (x ^ z);
      default: return x;
    endcase
  endfunction

  function automatic logic ref_parity(input logic [7:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_y     = 8'h00;
    m_acc   = 8'h00;
    m_cnt   = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"}, bus.out_valid, m_valid);
    check({tag, ".y"},         bus.y,         m_y);
    check({tag, ".zero"},      bus.zero,      m_y == 8'h00);
    check({tag, ".parity"},    bus.parity,    ref_parity(m_y));
    check({tag, ".acc"},       bus.acc,       m_acc);
    check({tag, ".txn_cnt"},   bus.txn_cnt,   m_cnt);
  endtask

  // Called at a negedge; applies one cycle of stimulus and checks the result
  task automatic step(input logic v, input int o, input logic [7:0] ia, input logic [7:0] ib,
                      input logic ae, input logic ac, input logic orr, input string tag);
    logic       rdy;
    logic [7:0] bb;
    logic [7:0] r;
    bus.in_valid  = v;
    bus.op        = 3'(o);
    bus.a         = ia;
    bus.b         = ib;
    bus.acc_en    = ae;
    bus.acc_clr   = ac;
    bus.out_ready = orr;
    #1;
    rdy = !m_valid || orr;
    check({tag, ".in_ready"}, bus.in_ready, rdy);
    @(posedge clk);
    bb = ae ? (ac ? 8'h00 : m_acc) : ib;
    r  = ref_fn(o, ia, bb);
    if (v && rdy) begin
      m_valid = 1'b1;
      m_y     = r;
      m_acc   = r;
      m_cnt   = (m_cnt + 1) % CNT_MOD;
    end else begin
      if (orr) m_valid = 1'b0;
      if (ac)  m_acc   = 8'h00;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    sweep_exp[0] = 8'h5A; sweep_exp[1] = 8'h05; sweep_exp[2] = 8'hFA; sweep_exp[3] = 8'hAF;
    sweep_exp[4] = 8'h50; sweep_exp[5] = 8'hAA; sweep_exp[6] = 8'h55; sweep_exp[7] = 8'hA5;

    bus.in_valid = 1'b0; bus.op = 3'd0; bus.a = 8'h00; bus.b = 8'h00;
    bus.acc_en = 1'b0; bus.acc_clr = 1'b0; bus.out_ready = 1'b0;
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;
    #1;
    check("reset.in_ready", bus.in_ready, 1'b1);
    @(negedge clk);

    // First transaction: AND
    step(1, 1, 8'hF0, 8'h3C, 0, 0, 1, "and");
    check("and.y_const", bus.y, 8'h30);
    check("and.cnt_const", bus.txn_cnt, 1);

    // Op sweep back-to-back
    for (int i = 0; i < 8; i++) begin
      step(1, i, 8'hA5, 8'h0F, 0, 0, 1, "sweep");
      check("sweep.y_const", bus.y, sweep_exp[i]);
    end

    // Backpressure: hold result while downstream stalls
    step(1, 5, 8'hFF, 8'hFF, 0, 0, 1, "bp_load");
    for (int i = 0; i < 3; i++) begin
      step(1, 5, 8'h12, 8'h34, 0, 0, 0, "bp_hold");
      check("bp_hold.y_const", bus.y, 8'h00);
      check("bp_hold.zero_const", bus.zero, 1'b1);
    end
    step(1, 5, 8'h12, 8'h34, 0, 0, 1, "bp_release");
    check("bp_release.y_const", bus.y, 8'h26);

    // Accumulate chaining and clear-with-accept
    step(1, 7, 8'h0F, 8'h00, 0, 0, 1, "acc_pass");
    step(1, 3, 8'hF0, 8'h00, 1, 0, 1, "acc_or");
    check("acc_or.y_const", bus.y, 8'hFF);
    step(1, 5, 8'h01, 8'h55, 1, 1, 1, "acc_clr");
    check("acc_clr.y_const", bus.y, 8'h01);
    check("acc_clr.acc_const", bus.acc, 8'h01);

    // acc_clr without in_valid
    step(0, 0, 8'h00, 8'h00, 0, 1, 1, "clr_idle");
    check("clr_idle.acc_const", bus.acc, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 7), 8'($urandom), 8'($urandom),
           $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, "rand");
    end

    // Async reset while a result is held
    step(0, 0, 8'h00, 8'h00, 0, 0, 1, "drain");
    step(1, 6, 8'h3C, 8'hC0, 0, 0, 0, "pre_rst");
    step(0, 0, 8'h00, 8'h00, 0, 0, 0, "pre_rst_hold");
    check("pre_rst.out_valid_const", bus.out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step(1, 1, 8'hF0, 8'h3C, 0, 0, 1, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
